// File: rtl/tour_cmd_seq_if.sv
// RemoteComm command/response handshake bundle between the sequencer (master)
// and the RemoteComm transmitter/receiver (slave).
interface tour_cmd_seq_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output snd_cmd,
    input  cmd_snt,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  snd_cmd,
    output cmd_snt,
    output resp_rdy,
    output resp
  );
endinterface

// File: rtl/tour_cmd_seq.sv
// Queued command sequencer for RemoteComm with ack/NAK/timeout handling.
// Optional macro TOUR_SEQ_RETRY_EN: retry a timed-out command up to twice before erroring.
module tour_cmd_seq #(
  parameter int TIMEOUT_CLKS = 100000000,
  parameter int DEPTH        = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [15:0]    load_cmd,
  input  logic           start,
  input  logic           abort,
  tour_cmd_seq_if.master rc,
  output logic           full,
  output logic           empty,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [7:0]     acked
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       ACK_BYTE = 8'hA5;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, ERROR} state_e;

  state_e             state_q, state_d;
  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               snd_cmd_q, snd_cmd_d;
  logic               full_q, full_d, empty_q, empty_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         acked_q, acked_d;
  logic               push_s, pop_s, start_acc_s, timeout_hit_s, retry_left_s;
  logic               bypass_s;
  logic [15:0]        head_s;

  // Next-state, queue bookkeeping and registered-output computation.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    tmo_d         = tmo_q;
    cmd_d         = cmd_q;
    done_d        = 1'b0;
    err_d         = err_q;
    err_code_d    = err_code_q;
    acked_d       = acked_q;
    pop_s         = 1'b0;
    start_acc_s   = 1'b0;
    timeout_hit_s = 1'b0;
    push_s        = load && !abort && (count_q != DEPTH_C);

    if (abort) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      tmo_d    = '0;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (start) begin
            start_acc_s = 1'b1;
            err_d       = 1'b0;
            err_code_d  = 2'b00;
            acked_d     = 8'd0;
            if (count_q != '0) begin
              state_d = SEND;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        SEND: begin
          state_d = WAIT_SNT;
        end
        WAIT_SNT: begin
          if (rc.cmd_snt) begin
            state_d = WAIT_RESP;
            tmo_d   = '0;
          end else begin
            state_d = WAIT_SNT;
          end
        end
        WAIT_RESP: begin
          if (rc.resp_rdy) begin
            if (rc.resp == ACK_BYTE) begin
              pop_s   = 1'b1;
              acked_d = (acked_q == 8'hFF) ? acked_q : acked_q + 8'd1;
              // A load landing in this same cycle keeps the sequence going.
              if ((count_q != CNT_W'(1)) || push_s) begin
                state_d = SEND;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              state_d    = ERROR;
              err_d      = 1'b1;
              err_code_d = 2'b01;
            end
          end else if (tmo_q == TMO_LAST) begin
            timeout_hit_s = 1'b1;
            if (retry_left_s) begin
              state_d = SEND;
            end else begin
              state_d    = ERROR;
              err_d      = 1'b1;
              err_code_d = 2'b10;
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // The new head may be the word being written this very cycle.
    bypass_s = push_s && (count_q == CNT_W'(pop_s));
    head_s   = bypass_s ? load_cmd : mem_q[rd_ptr_d];
    if (state_d == SEND) begin
      cmd_d = head_s;
    end else begin
      cmd_d = cmd_q;
    end
    snd_cmd_d = (state_d == SEND);
    busy_d    = (state_d == SEND) || (state_d == WAIT_SNT) || (state_d == WAIT_RESP);
    full_d    = (count_d == DEPTH_C);
    empty_d   = (count_d == '0);
  end

  // State, queue pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      cmd_q      <= 16'h0000;
      snd_cmd_q  <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      acked_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      snd_cmd_q  <= snd_cmd_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      acked_q    <= acked_d;
    end
  end

  // Queue storage; validity is defined by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_q[wr_ptr_q] <= load_cmd;
    end
  end

`ifdef TOUR_SEQ_RETRY_EN
  logic [1:0] retry_q, retry_d;

  // Retry count for the current head: cleared on pop or start, bumped per retried timeout.
  always_comb begin
    if (pop_s || start_acc_s) begin
      retry_d = 2'd0;
    end else if (timeout_hit_s && retry_left_s) begin
      retry_d = retry_q + 2'd1;
    end else begin
      retry_d = retry_q;
    end
  end

  // Retry counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retry_q <= 2'd0;
    end else begin
      retry_q <= retry_d;
    end
  end

  assign retry_left_s = (retry_q != 2'd2);
`else
  assign retry_left_s = 1'b0;
`endif

  assign rc.cmd     = cmd_q;
  assign rc.snd_cmd = snd_cmd_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign acked      = acked_q;

endmodule

// File: doc/tour_cmd_seq.md
TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 100000000, is the clocks allowed from cmd_snt to resp_rdy before timeout.
REQ-002 Parameter DEPTH, default 8 (power of 2), is the command queue depth.
REQ-003 clk  input  1  system clock; all logic is rising-edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 load  input  1  push load_cmd into the queue.
REQ-006 load_cmd  input  16  command word to queue.
REQ-007 start  input  1  begin issuing the queued commands.
REQ-008 abort  input  1  stop the sequence and flush the queue.
REQ-009 cmd_snt  input  1  one-cycle pulse from RemoteComm: all command bytes are transmitted.
REQ-010 resp_rdy  input  1  one-cycle pulse from RemoteComm: resp is valid.
REQ-011 resp  input  8  response byte; 8'hA5 is a positive acknowledge.
REQ-012 cmd  output  16  command word presented to RemoteComm.
REQ-013 snd_cmd  output  1  one-cycle send strobe to RemoteComm.
REQ-014 full  output  1  queue holds DEPTH entries.
REQ-015 empty  output  1  queue holds 0 entries.
REQ-016 busy  output  1  sequence in progress.
REQ-017 done  output  1  one-cycle pulse: all queued commands were acknowledged.
REQ-018 err  output  1  sticky error flag; cleared by start or reset.
REQ-019 err_code  output  2  error cause: 01 = NAK (resp other than A5), 10 = timeout, 00 = none.
REQ-020 acked  output  8  count of commands acknowledged since the last start; saturates at 255.

Function
REQ-021 The queue is a FIFO; a load while full is ignored and does not corrupt contents.
REQ-022 load is accepted in every state, including the same cycle as an internal pop; occupancy then stays unchanged.
REQ-023 The FSM has states IDLE, SEND, WAIT_SNT, WAIT_RESP, and ERROR.
REQ-024 In IDLE, start with a non-empty queue goes to SEND; start with an empty queue pulses done on the next cycle and remains in IDLE.
REQ-025 SEND loads cmd from the queue head, asserts snd_cmd for exactly one cycle, and goes to WAIT_SNT.
REQ-026 cmd is held stable from SEND until the response for that command is resolved.
REQ-027 In WAIT_SNT, cmd_snt goes to WAIT_RESP and clears the timeout counter.
REQ-028 In WAIT_RESP, the timeout counter increments each cycle.
REQ-029 In WAIT_RESP, resp_rdy with resp=A5 pops the head and increments acked; the FSM then goes to SEND if the queue is non-empty, otherwise pulses done and goes to IDLE.
REQ-030 In WAIT_RESP, resp_rdy with any other resp goes to ERROR with err_code=01; the head is not popped.
REQ-031 In WAIT_RESP, the counter reaching TIMEOUT_CLKS-1 with no resp_rdy is a timeout (handling per REQ-040/041).
REQ-032 If resp_rdy and the timeout occur in the same cycle, resp_rdy wins.
REQ-033 ERROR holds err=1 and busy=0; only start (re-arm: err cleared, resume with the unpopped head) or abort leaves ERROR.
REQ-034 abort has priority over every other input in any state: it goes to IDLE next cycle, flushes the queue, and suppresses snd_cmd and done; err and acked are retained.
REQ-035 busy=1 in SEND, WAIT_SNT, and WAIT_RESP; busy=0 otherwise.
REQ-036 start while busy is ignored.

Reset
REQ-037 rst_n=0 at a clock edge forces IDLE, empties the queue, and clears the timeout and retry counters.
REQ-038 During and after reset, outputs are: cmd=0, snd_cmd=0, full=0, empty=1, busy=0, done=0, err=0, err_code=00, acked=0.
REQ-039 Reset asserted mid-sequence discards any outstanding command; a later cmd_snt or resp_rdy arriving in IDLE is ignored.

Configuration
REQ-040 With macro TOUR_SEQ_RETRY_EN defined, a timeout re-enters SEND with the same head, up to 2 retries per command; the retry counter resets on each pop; a timeout after the 2nd retry goes to ERROR with err_code=10.
REQ-041 Without TOUR_SEQ_RETRY_EN, the first timeout goes directly to ERROR with err_code=10, and no retry counter is instantiated.

Verification (TIMEOUT_CLKS=1000)
REQ-042 Load 2FFF, 4BF1; start; model acks each with A5 -> two snd_cmd pulses in order, cmd=2FFF then 4BF1, acked=2, one done pulse, empty=1.
REQ-043 Load 4BF1; start; model responds 5A -> err=1, err_code=01, empty=0; start again with A5 -> cmd=4BF1 re-sent, done pulse, err=0.
REQ-044 Load 1 cmd; start; withhold resp_rdy -> RETRY_EN: 3 snd_cmd pulses then err_code=10; no RETRY_EN: 1 pulse then err_code=10 at 1000 clks after cmd_snt.
REQ-045 Load DEPTH+1 commands -> full=1 after DEPTH loads, last load dropped, DEPTH commands issued.
REQ-046 Abort during WAIT_RESP with 3 queued -> IDLE next cycle, empty=1, no done pulse, a late resp_rdy is ignored.
REQ-047 Assert rst_n=0 mid-WAIT_SNT -> all outputs take the REQ-038 values on the next edge.
